// File: rtl/alu_status_pkg.sv
// Shared definitions for the ALU status register slice.
// Flag bit positions, condition-code selectors and the flag vector type.
package alu_status_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_status_register_cond_evaluator.sv
// Combinational condition-code evaluator over a {V,C,S,Z} flag vector.
// Ports: flags[3:0], cond_code[3:0] in; cond_true out.
module cond_evaluator
  import alu_status_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond_code,
  output logic       cond_true
);

  logic z;
  logic s;
  logic c;
  logic v;

  assign z = flags[FLAG_Z];
  assign s = flags[FLAG_S];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond_code)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = s;
      COND_PL: cond_true = !s;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !c | z;
      COND_GE: cond_true = (s == v);
      COND_LT: cond_true = (s != v);
      COND_GT: cond_true = !z & (s == v);
      COND_LE: cond_true = z | (s != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_register.sv
// Status register: masked flag capture, shadow save/restore, sticky V.
// Ports: update handshake, save/restore, sticky_clr, cond query/answer.
module alu_status_register
  import alu_status_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             zero_flag,
  input  logic             sign_flag,
  input  logic             carry_flag,
  input  logic             overflow_flag,
  input  logic [3:0]       flag_mask,
  input  logic             flag_save,
  input  logic             flag_restore,
  input  logic             sticky_clr,
  input  logic             cond_req,
  input  logic [3:0]       cond_code,
  output logic [3:0]       status,
  output logic [WIDTH-1:0] result_q,
  output logic             sticky_ovf,
  output logic             ovf_irq,
  output logic             cond_ack,
  output logic             cond_true
);

  flags_t status_q;
  flags_t shadow_q;
  flags_t upd;
  flags_t fwd;
  logic   accept;
  logic   ovf_set;
  logic   hit;

  assign in_ready = !flag_restore;
  assign accept   = in_valid & in_ready;
  assign status   = status_q;

  always_comb begin
    upd         = '0;
    upd[FLAG_Z] = zero_flag;
    upd[FLAG_S] = sign_flag;
    upd[FLAG_C] = carry_flag;
    upd[FLAG_V] = overflow_flag;
  end

  // Value status takes at the coming edge; also feeds the
  // condition evaluator so a same-cycle update is visible.
  always_comb begin
    fwd = status_q;
    if (flag_restore)
      fwd = shadow_q;
    else if (accept)
      fwd = (upd & flag_mask) | (status_q & ~flag_mask);
  end

  assign ovf_set = accept & flag_mask[FLAG_V] & overflow_flag;

  cond_evaluator u_cond (
    .flags     (fwd),
    .cond_code (cond_code),
    .cond_true (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= '0;
      shadow_q   <= '0;
      result_q   <= '0;
      sticky_ovf <= 1'b0;
      ovf_irq    <= 1'b0;
      cond_ack   <= 1'b0;
      cond_true  <= 1'b0;
    end else begin
      status_q <= fwd;
      // Pre-edge status, so save+restore swaps.
      if (flag_save)
        shadow_q <= status_q;
      if (accept)
        result_q <= result;
      sticky_ovf <= ovf_set | (sticky_ovf & !sticky_clr);
      ovf_irq    <= ovf_set & !sticky_ovf;
      cond_ack   <= cond_req;
      cond_true  <= cond_req & hit;
    end
  end

endmodule

// File: tb/tb_alu_status_register.sv
// Self-checking bench for alu_status_register.
// Vector table + scoreboard queue, cond sweep, reset-during-query.
module tb_alu_status_register;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        overflow_flag;
  logic [3:0]  flag_mask;
  logic        flag_save;
  logic        flag_restore;
  logic        sticky_clr;
  logic        cond_req;
  logic [3:0]  cond_code;
  logic [3:0]  status;
  logic [31:0] result_q;
  logic        sticky_ovf;
  logic        ovf_irq;
  logic        cond_ack;
  logic        cond_true;

  int checks = 0;
  int errors = 0;

  alu_status_register #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .result        (result),
    .zero_flag     (zero_flag),
    .sign_flag     (sign_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .flag_mask     (flag_mask),
    .flag_save     (flag_save),
    .flag_restore  (flag_restore),
    .sticky_clr    (sticky_clr),
    .cond_req      (cond_req),
    .cond_code     (cond_code),
    .status        (status),
    .result_q      (result_q),
    .sticky_ovf    (sticky_ovf),
    .ovf_irq       (ovf_irq),
    .cond_ack      (cond_ack),
    .cond_true     (cond_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] fl;
    logic [3:0] m;
    logic [7:0] r;
    logic       sv;
    logic       rs;
    logic       sc;
    logic       cq;
    logic [3:0] cc;
    logic [3:0] st;
    logic [7:0] rq;
    logic       sk;
    logic       irq;
    logic       ack;
    logic       ct;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [31:0] rq;
    logic        sk;
    logic        irq;
    logic        ack;
    logic        ct;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[22];

  function automatic vec_t mk(
    input logic v, input logic [3:0] fl, input logic [3:0] m,
    input logic [7:0] r, input logic sv, input logic rs,
    input logic sc, input logic cq, input logic [3:0] cc,
    input logic [3:0] st, input logic [7:0] rq, input logic sk,
    input logic irq, input logic ack, input logic ct);
    vec_t t;
    t.v = v; t.fl = fl; t.m = m; t.r = r;
    t.sv = sv; t.rs = rs; t.sc = sc; t.cq = cq; t.cc = cc;
    t.st = st; t.rq = rq; t.sk = sk; t.irq = irq;
    t.ack = ack; t.ct = ct;
    return t;
  endfunction

  function automatic logic ref_cond(input logic [3:0] f,
                                    input logic [3:0] code);
    logic z, s, c, v, b;
    z = f[0]; s = f[1]; c = f[2]; v = f[3];
    case (code[3:1])
      3'd0:    b = z;
      3'd1:    b = c;
      3'd2:    b = s;
      3'd3:    b = v;
      3'd4:    b = c && !z;
      3'd5:    b = (s == v);
      3'd6:    b = !z && (s == v);
      default: b = 1'b1;
    endcase
    return code[0] ? !b : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; result = '0;
    zero_flag = 0; sign_flag = 0; carry_flag = 0; overflow_flag = 0;
    flag_mask = '0; flag_save = 0; flag_restore = 0;
    sticky_clr = 0; cond_req = 0; cond_code = '0;
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    exp_t g;
    @(negedge clk);
    in_valid = t.v;
    result = {24'h0, t.r};
    zero_flag = t.fl[0]; sign_flag = t.fl[1];
    carry_flag = t.fl[2]; overflow_flag = t.fl[3];
    flag_mask = t.m; flag_save = t.sv; flag_restore = t.rs;
    sticky_clr = t.sc; cond_req = t.cq; cond_code = t.cc;
    e.st = t.st; e.rq = {24'h0, t.rq}; e.sk = t.sk;
    e.irq = t.irq; e.ack = t.ack; e.ct = t.ct;
    sb.push_back(e);
    #1;
    chk("in_ready", {31'h0, in_ready}, {31'h0, !t.rs});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = sb.pop_front();
      chk("status", {28'h0, status}, {28'h0, g.st});
      chk("result_q", result_q, g.rq);
      chk("sticky_ovf", {31'h0, sticky_ovf}, {31'h0, g.sk});
      chk("ovf_irq", {31'h0, ovf_irq}, {31'h0, g.irq});
      chk("cond_ack", {31'h0, cond_ack}, {31'h0, g.ack});
      chk("cond_true", {31'h0, cond_true}, {31'h0, g.ct});
    end
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"}, {28'h0, status}, 32'h0);
    chk({tag, "_result_q"}, result_q, 32'h0);
    chk({tag, "_sticky"}, {31'h0, sticky_ovf}, 32'h0);
    chk({tag, "_irq"}, {31'h0, ovf_irq}, 32'h0);
    chk({tag, "_ack"}, {31'h0, cond_ack}, 32'h0);
    chk({tag, "_true"}, {31'h0, cond_true}, 32'h0);
  endtask

  initial begin
    logic [3:0] pats[5];
    logic       sk_exp;
    idle_inputs();
    rst_n = 1'b0;

    // v  fl     m     r    sv rs sc cq cc  | st   rq  sk irq ack ct
    tbl[0]  = mk(1, 4'b0101, 4'b1111, 8'h11, 0,0,0,0, 4'd0,  4'b0101, 8'h11, 0,0,0,0);
    tbl[1]  = mk(1, 4'b0010, 4'b0010, 8'h22, 0,0,0,0, 4'd0,  4'b0111, 8'h22, 0,0,0,0);
    tbl[2]  = mk(1, 4'b1000, 4'b1000, 8'h33, 0,0,0,0, 4'd0,  4'b1111, 8'h33, 1,1,0,0);
    tbl[3]  = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,0, 4'd0,  4'b1111, 8'h33, 1,0,0,0);
    tbl[4]  = mk(1, 4'b1000, 4'b1000, 8'h44, 0,0,0,0, 4'd0,  4'b1111, 8'h44, 1,0,0,0);
    tbl[5]  = mk(1, 4'b1000, 4'b1000, 8'h55, 0,0,1,0, 4'd0,  4'b1111, 8'h55, 1,0,0,0);
    tbl[6]  = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,1,0, 4'd0,  4'b1111, 8'h55, 0,0,0,0);
    tbl[7]  = mk(1, 4'b1000, 4'b1111, 8'h66, 0,0,0,0, 4'd0,  4'b1000, 8'h66, 1,1,0,0);
    tbl[8]  = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,1, 4'd10, 4'b1000, 8'h66, 1,0,1,0);
    tbl[9]  = mk(1, 4'b0000, 4'b1010, 8'h77, 0,0,0,1, 4'd10, 4'b0000, 8'h77, 1,0,1,1);
    tbl[10] = mk(1, 4'b0101, 4'b1111, 8'h88, 0,0,0,0, 4'd0,  4'b0101, 8'h88, 1,0,0,0);
    tbl[11] = mk(0, 4'b0000, 4'b0000, 8'h00, 1,0,0,0, 4'd0,  4'b0101, 8'h88, 1,0,0,0);
    tbl[12] = mk(1, 4'b0000, 4'b1111, 8'h99, 0,0,0,0, 4'd0,  4'b0000, 8'h99, 1,0,0,0);
    tbl[13] = mk(1, 4'b1111, 4'b1111, 8'hAA, 0,1,0,1, 4'd0,  4'b0101, 8'h99, 1,0,1,1);
    tbl[14] = mk(1, 4'b1100, 4'b1111, 8'hBB, 0,0,0,0, 4'd0,  4'b1100, 8'hBB, 1,0,0,0);
    tbl[15] = mk(0, 4'b0000, 4'b0000, 8'h00, 1,0,0,0, 4'd0,  4'b1100, 8'hBB, 1,0,0,0);
    tbl[16] = mk(1, 4'b0011, 4'b1111, 8'hCC, 0,0,0,0, 4'd0,  4'b0011, 8'hCC, 1,0,0,0);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 8'h00, 1,1,0,0, 4'd0,  4'b1100, 8'hCC, 1,0,0,0);
    tbl[18] = mk(0, 4'b0000, 4'b0000, 8'h00, 0,1,0,0, 4'd0,  4'b0011, 8'hCC, 1,0,0,0);
    tbl[19] = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,1, 4'd14, 4'b0011, 8'hCC, 1,0,1,1);
    tbl[20] = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,1, 4'd15, 4'b0011, 8'hCC, 1,0,1,0);
    tbl[21] = mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,0, 4'd0,  4'b0011, 8'hCC, 1,0,0,0);

    #1;
    chk_all_zero("reset");
    flag_restore = 1'b1;
    #1;
    chk("reset_in_ready_restore", {31'h0, in_ready}, 32'h0);
    flag_restore = 1'b0;
    #1;
    chk("reset_in_ready_idle", {31'h0, in_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) step(tbl[i]);

    // Clear sticky so the sweep starts from a known sticky state.
    step(mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,1,0, 4'd0,
            4'b0011, 8'hCC, 0,0,0,0));
    sk_exp = 1'b0;

    pats[0] = 4'b0000; pats[1] = 4'b0101; pats[2] = 4'b1010;
    pats[3] = 4'b1001; pats[4] = 4'b0110;
    for (int p = 0; p < 5; p++) begin
      logic irq_e;
      irq_e = pats[p][3] & !sk_exp;
      sk_exp = sk_exp | pats[p][3];
      step(mk(1, pats[p], 4'b1111, {4'h0, pats[p]}, 0,0,0,0, 4'd0,
              pats[p], {4'h0, pats[p]}, sk_exp, irq_e, 0, 0));
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cc;
        cc = c[3:0];
        step(mk(0, 4'b0000, 4'b0000, 8'h00, 0,0,0,1, cc,
                pats[p], {4'h0, pats[p]}, sk_exp, 0, 1,
                ref_cond(pats[p], cc)));
      end
    end

    // AL query answered, then reset lands before the NV answer.
    @(negedge clk);
    cond_req = 1'b1; cond_code = 4'd14;
    @(posedge clk);
    #1;
    chk("al_ack", {31'h0, cond_ack}, 32'h1);
    chk("al_true", {31'h0, cond_true}, 32'h1);
    @(negedge clk);
    cond_req = 1'b1; cond_code = 4'd15;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("post_rst");

    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
